multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS datapath: a Moore-style FSM that walks each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select. It sits beside the shared memory, the ALU and the register file. It stalls on a memory-ready handshake, so a single unified memory can serve both instruction and data accesses.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mc_output_decode.sv | 90 +++++++++
 rtl/multicycle_control.sv | 99 +++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM state
// codes, ALU/mux select encodings and the packed control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pc_write and branch stay internal; the top folds them into pc_en with zero
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode of the control word from the current state; only
// FETCH and MEMWR look at mem_ready. Optional addi states need MC_ADDI_EN.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: state register, next-state logic and pc_en.
// Define MC_ADDI_EN to add the addi execute/writeback states.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   op_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory states hold until mem_ready; opcode is only consulted in DECODE/MEMADR
  always_comb begin
    state_d    = state_q;
    op_illegal = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default: begin
            state_d    = FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
`ifdef MC_ADDI_EN
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  // An unsupported opcode retires straight out of DECODE
  assign instr_done = ctrl.instr_done | op_illegal;
  assign illegal    = op_illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: walks R-type, lw, sw,
// beq, j, illegal and addi instructions plus stalls and mid-instruction reset.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [16:0] obs;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal};

  // Builds an expected control vector in the same field order as obs
  function automatic logic [16:0] cw(input logic pe, iod, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, aop, psrc,
                                     input logic dn, il);
    return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, psrc, dn, il};
  endfunction

  logic [16:0] eIdle, eFetch, eFetchStall, eDecode, eExec, eAluwb, eMemadr, eMemrd;
  logic [16:0] eMemwb, eMemwrWait, eMemwrDone, eBrTaken, eBrNot, eJump, eIllegal;
  logic [16:0] eAddiex, eAddiwb;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic z);
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expState,
                             input logic [16:0] expCtrl);
    checks++;
    assert (state === expState) else begin
      failures++;
      $display("[TB] FAIL %s_state observed=%0d expected=%0d", tag, state, expState);
      $error("[TB] %s_state observed=%0d expected=%0d", tag, state, expState);
    end
    checks++;
    assert (obs === expCtrl) else begin
      failures++;
      $display("[TB] FAIL %s_ctrl observed=%b expected=%b", tag, obs, expCtrl);
      $error("[TB] %s_ctrl observed=%b expected=%b", tag, obs, expCtrl);
    end
  endtask

  initial begin
    //             pe iod mr mw irw rd m2r rw sa  sb     aop    psrc  dn il
    eIdle       = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    eFetch      = cw(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    eFetchStall = cw(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    eDecode     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    eExec       = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    eAluwb      = cw(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    eMemadr     = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    eMemrd      = cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    eMemwb      = cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    eMemwrWait  = cw(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    eMemwrDone  = cw(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    eBrTaken    = cw(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    eBrNot      = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    eJump       = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    eIllegal    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 1);
    eAddiex     = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    eAddiwb     = cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);

    // Reset held, then released; first fetch one edge later
    rst_n = 1'b0;
    applyStimulus(6'b000000, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset", 4'd0, eIdle);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_after_release", 4'd0, eIdle);

    // R-type: 1,2,7,8,1 with an opcode change in EXEC that must be ignored
    tick(); checkOutput("rtype_fetch", 4'd1, eFetch);
    tick(); checkOutput("rtype_decode", 4'd2, eDecode);
    tick(); checkOutput("rtype_exec", 4'd7, eExec);
    applyStimulus(6'b100011, 1'b1, 1'b0);
    tick(); checkOutput("rtype_aluwb", 4'd8, eAluwb);
    tick(); checkOutput("lw_fetch", 4'd1, eFetch);

    // lw with three wait cycles in MEMRD
    tick(); checkOutput("lw_decode", 4'd2, eDecode);
    tick(); checkOutput("lw_memadr", 4'd3, eMemadr);
    tick();
    applyStimulus(6'b100011, 1'b0, 1'b0);
    checkOutput("lw_memrd_w1", 4'd4, eMemrd);
    tick(); checkOutput("lw_memrd_w2", 4'd4, eMemrd);
    tick(); checkOutput("lw_memrd_w3", 4'd4, eMemrd);
    tick();
    applyStimulus(6'b100011, 1'b1, 1'b0);
    checkOutput("lw_memrd_rdy", 4'd4, eMemrd);
    tick(); checkOutput("lw_memwb", 4'd5, eMemwb);

    // sw with a one-cycle FETCH stall and a one-cycle MEMWR stall
    tick();
    applyStimulus(6'b101011, 1'b0, 1'b0);
    checkOutput("sw_fetch_stall", 4'd1, eFetchStall);
    tick(); checkOutput("sw_fetch_hold", 4'd1, eFetchStall);
    applyStimulus(6'b101011, 1'b1, 1'b0);
    checkOutput("sw_fetch_rdy", 4'd1, eFetch);
    tick(); checkOutput("sw_decode", 4'd2, eDecode);
    tick(); checkOutput("sw_memadr", 4'd3, eMemadr);
    tick();
    applyStimulus(6'b101011, 1'b0, 1'b0);
    checkOutput("sw_memwr_wait", 4'd6, eMemwrWait);
    tick(); checkOutput("sw_memwr_hold", 4'd6, eMemwrWait);
    applyStimulus(6'b101011, 1'b1, 1'b0);
    checkOutput("sw_memwr_done", 4'd6, eMemwrDone);
    tick(); checkOutput("beq1_fetch", 4'd1, eFetch);

    // beq taken then not taken
    applyStimulus(6'b000100, 1'b1, 1'b1);
    tick(); checkOutput("beq1_decode", 4'd2, eDecode);
    tick(); checkOutput("beq1_branch", 4'd9, eBrTaken);
    tick(); checkOutput("beq2_fetch", 4'd1, eFetch);
    applyStimulus(6'b000100, 1'b1, 1'b0);
    tick(); checkOutput("beq2_decode", 4'd2, eDecode);
    tick(); checkOutput("beq2_branch", 4'd9, eBrNot);
    tick(); checkOutput("j_fetch", 4'd1, eFetch);

    // jump
    applyStimulus(6'b000010, 1'b1, 1'b0);
    tick(); checkOutput("j_decode", 4'd2, eDecode);
    tick(); checkOutput("j_jump", 4'd10, eJump);
    tick(); checkOutput("ill_fetch", 4'd1, eFetch);

    // unsupported opcode retires from DECODE
    applyStimulus(6'b111111, 1'b1, 1'b0);
    tick(); checkOutput("ill_decode", 4'd2, eIllegal);
    tick(); checkOutput("addi_fetch", 4'd1, eFetch);

    // addi: real instruction with MC_ADDI_EN, otherwise illegal
    applyStimulus(6'b001000, 1'b1, 1'b0);
`ifdef MC_ADDI_EN
    tick(); checkOutput("addi_decode", 4'd2, eDecode);
    tick(); checkOutput("addi_ex", 4'd11, eAddiex);
    tick(); checkOutput("addi_wb", 4'd12, eAddiwb);
`else
    tick(); checkOutput("addi_decode_ill", 4'd2, eIllegal);
`endif
    tick(); checkOutput("rst_fetch", 4'd1, eFetch);

    // reset asserted in the middle of a stalled sw
    applyStimulus(6'b101011, 1'b1, 1'b0);
    tick(); checkOutput("rst_decode", 4'd2, eDecode);
    tick(); checkOutput("rst_memadr", 4'd3, eMemadr);
    tick();
    applyStimulus(6'b101011, 1'b0, 1'b0);
    checkOutput("rst_memwr", 4'd6, eMemwrWait);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_midwr", 4'd0, eIdle);
    #1;
    rst_n = 1'b1;
    applyStimulus(6'b000000, 1'b1, 1'b0);
    tick(); checkOutput("rst_refetch", 4'd1, eFetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
